// File: rtl/irq_arbiter.sv
// Edge-triggered, maskable, fixed-priority interrupt arbiter for the single-cycle MIPS core.
// Sequences one non-nested ISR at a time and supplies the vector address of the current winner.
module irq_arbiter #(
  parameter int          NUM_SRC    = 4,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               irq_entry,
  input  logic               irq_resume,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wd,
  input  logic [NUM_SRC-1:0] ovf_clr,
  output logic               irq,
  output logic               irq_active,
  output logic [2:0]         irq_id,
  output logic [31:0]        isr_addr,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] mask,
  output logic [NUM_SRC-1:0] ovf
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [NUM_SRC-1:0] r_src_q;
  logic [NUM_SRC-1:0] r_pending;
  logic [NUM_SRC-1:0] r_mask;
  logic [NUM_SRC-1:0] r_ovf;
  logic [2:0]         r_irq_id;

  logic [NUM_SRC-1:0] w_edge;
  logic [NUM_SRC-1:0] w_req;
  logic               w_any;
  logic [2:0]         w_sel_id;
  logic               w_ack;
  logic [NUM_SRC-1:0] w_clr;

  assign w_edge = irq_src & ~r_src_q;
  assign w_req  = r_pending & r_mask;
  assign w_any  = |w_req;

  // Lowest pending-and-enabled index wins.
  always_comb begin
    w_sel_id = 3'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_req[i]) begin
        w_sel_id = 3'(i);
      end else begin
        w_sel_id = w_sel_id;
      end
    end
  end

  assign w_ack = (r_state == ST_IDLE) && irq_entry && w_any;
  assign w_clr = w_ack ? (NUM_SRC'(1) << w_sel_id) : {NUM_SRC{1'b0}};

  // FSM next-state and request/active outputs; entry/resume only affect the next cycle.
  always_comb begin
    w_state_nxt = r_state;
    irq         = 1'b0;
    irq_active  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        irq = w_any;
        if (w_ack) begin
          w_state_nxt = ST_ACTIVE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        irq_active = 1'b1;
        if (irq_resume) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_ACTIVE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Edge history, pending/overflow flags, mask and serviced id; a new edge beats the ack clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src_q   <= {NUM_SRC{1'b0}};
      r_pending <= {NUM_SRC{1'b0}};
      r_ovf     <= {NUM_SRC{1'b0}};
      r_mask    <= {NUM_SRC{1'b0}};
      r_irq_id  <= 3'd0;
    end else begin
      r_src_q   <= irq_src;
      r_pending <= (r_pending & ~w_clr) | w_edge;
      r_ovf     <= (r_ovf & ~ovf_clr) | (w_edge & r_pending & ~w_clr);
      if (mask_we) begin
        r_mask <= mask_wd;
      end else begin
        r_mask <= r_mask;
      end
      if (w_ack) begin
        r_irq_id <= w_sel_id;
      end else begin
        r_irq_id <= r_irq_id;
      end
    end
  end

  assign isr_addr = VEC_BASE + ({29'd0, w_sel_id} * VEC_STRIDE);
  assign irq_id   = r_irq_id;
  assign pending  = r_pending;
  assign mask     = r_mask;
  assign ovf      = r_ovf;

endmodule

// File: doc/irq_arbiter.md
# irq_arbiter

Edge-triggered, maskable, fixed-priority interrupt arbiter for the single-cycle MIPS core. It collects up to `NUM_SRC` peripheral interrupt lines and drives the control unit's `irq` and `irq_active` inputs. It consumes the control unit's `irq_entry` and `irq_resume` strobes to sequence exactly one ISR at a time (no nesting). It also supplies the ISR vector address to the PC logic, and exposes mask and status registers to the memory-mapped I/O decoder.

## Interface
Parameters:
- `NUM_SRC`, 4: number of interrupt sources, 2..8.
- `VEC_BASE`, 32'h0000_0100: ISR vector of source 0.
- `VEC_STRIDE`, 32'h0000_0010: byte spacing between vectors.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  — system clock, rising edge.
- `rst_n`  in  1  — asynchronous active-low reset.
- `irq_src`  in  NUM_SRC  — peripheral lines, synchronous to `clk`, rising-edge significant.
- `irq_entry`  in  1  — control unit: ISR entered this cycle.
- `irq_resume`  in  1  — control unit: return-from-ISR executed this cycle.
- `mask_we`  in  1  — write enable for the mask register.
- `mask_wd`  in  NUM_SRC  — new mask; 1 = enabled.
- `ovf_clr`  in  NUM_SRC  — write-1-to-clear for overflow flags.
- `irq`  out  1  — interrupt request to the control unit.
- `irq_active`  out  1  — ISR in progress.
- `irq_id`  out  3  — source being serviced; only valid while `irq_active`.
- `isr_addr`  out  32  — `VEC_BASE + sel_id*VEC_STRIDE`, where `sel_id` is the current winner.
- `pending`  out  NUM_SRC  — pending flags.
- `mask`  out  NUM_SRC  — mask register.
- `ovf`  out  NUM_SRC  — sticky missed-edge flags.

## Operation
Edge detect:
- `src_q` is a register that holds `irq_src` from the previous cycle.
- An edge on source i is `irq_src[i] & ~src_q[i]`.

Pending flags:
- An edge sets `pending[i]`.
- If `pending[i]` is already 1 and is not being cleared this cycle, an edge also sets `ovf[i]`.
- `ovf[i]` clears only on `ovf_clr[i]`. If set and clear hit the same cycle, set wins.

Winner selection (combinational):
- `sel_id` is the lowest index i with `pending[i] & mask[i]`.
- `any = |(pending & mask)`.

State machine, two states:
- IDLE:
  - `irq = any`; `irq_active = 0`.
  - If `irq_entry & any`: clear `pending[sel_id]`, latch `irq_id <= sel_id`, go to ACTIVE.
  - If `irq_entry` arrives while `any = 0`: ignore it.
  - `irq_resume` is ignored.
- ACTIVE:
  - `irq = 0`; `irq_active = 1`.
  - Edges keep accumulating in `pending`.
  - If `irq_resume`: go to IDLE.
  - `irq_entry` is ignored.

Simultaneous events:
- New edge on `sel_id` in the same cycle as the ack clear: the bit stays 1 (set wins) and `ovf` is not set.
- `mask_we` in the same cycle as `irq_entry`: selection uses the old mask; the new mask takes effect next cycle.
- Masking a pending source does not clear its pending flag; unmasking it later raises `irq`.

Reset (asynchronous, `rst_n` low):
- State is IDLE.
- `pending`, `ovf`, `mask` (all sources disabled), `src_q` and `irq_id` are all 0.
- Therefore `irq = 0`, `irq_active = 0`, `isr_addr = VEC_BASE`.
- Reset asserted mid-ISR abandons the ISR immediately, with no resume required.

## Timing
- Edge sampled at clock edge k → `pending` set after edge k → `irq` high in cycle k+1. One cycle of latency from the source going high to `irq`.
- `irq` and `isr_addr` are combinational from registers. They are stable for the whole cycle in which the control unit asserts `irq_entry`.
- Entry ack at edge e → `irq_active = 1` and `irq = 0` from cycle e+1.
- Resume at edge r → IDLE from cycle r+1. The next pending winner raises `irq` in cycle r+1, which is back-to-back service with no idle gap.
- Mask write at edge w is visible in `mask`, `irq` and `isr_addr` from cycle w+1.
- No combinational path from `irq_entry` or `irq_resume` to `irq`, `irq_active` or `isr_addr`.

## Test plan
- Reset, then `mask=4'hF`, then pulse `irq_src[2]`: `irq=1` one cycle later, `isr_addr=32'h120`. Assert `irq_entry`: next cycle `irq_active=1`, `irq_id=2`, `pending=0`. Assert `irq_resume`: `irq_active=0`.
- Sources 1 and 3 rise in the same cycle: service 1 first (`isr_addr=32'h110`). After resume, `irq` is high in the very next cycle with `isr_addr=32'h130`.
- `mask=4'b1110`, pulse source 0: `pending=4'b0001`, `irq=0`. Write `mask=4'hF`: `irq=1` the next cycle, `isr_addr=32'h100`.
- Two edges on source 1 with no ack: `ovf[1]=1`, `pending[1]=1`. `ovf_clr=4'b0010` → `ovf=0`. An edge on source 1 in the same cycle as its ack clear → `pending[1]` stays 1, `ovf[1]=0`.
- Stray `irq_entry` in IDLE with nothing pending, and stray `irq_resume` in IDLE → no state change, all outputs unchanged.
- Assert `rst_n=0` asynchronously mid-ISR, between clock edges: `irq_active`, `pending` and `mask` go to 0 immediately. After release, the first source edge with its mask still 0 leaves `irq=0`.
